// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//
// Two-source round-robin arbiter that drives the select line of a downstream
// 2:1 data mux. It also captures the selected word into a single-entry output
// register that has its own valid/ready handshake.
//
// Optional feature macro: MUX_SEL_STICKY_EN
//   defined   : a grant is held for up to BURST_LEN beats while the other
//               source waits.
//   undefined : grant alternates every beat under contention. BURST_LEN is
//               only range-checked.
//
// Parameters:
//   WIDTH      data width of each source and of the output
//   BURST_LEN  max consecutive beats per grant under contention (1..16)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   din_0      source 0 data          valid_0 / ready_0  source 0 handshake
//   din_1      source 1 data          valid_1 / ready_1  source 1 handshake
//   sel        mux select, 0 = din_0, 1 = din_1 (decoded from state only)
//   mux_data   registered selected word
//   out_valid  mux_data holds an unconsumed word
//   out_ready  consumer accepts when out_valid & out_ready
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
    parameter int WIDTH     = 1,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_0,
    input  logic             valid_0,
    output logic             ready_0,
    input  logic [WIDTH-1:0] din_1,
    input  logic             valid_1,
    output logic             ready_1,
    output logic             sel,
    output logic [WIDTH-1:0] mux_data,
    output logic             out_valid,
    input  logic             out_ready
);

    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst
        $error("mux_sel_arbiter: BURST_LEN must be in 1..16");
    end

`ifdef MUX_SEL_STICKY_EN
    localparam int LIMIT = BURST_LEN;
`else
    localparam int LIMIT = 1;
`endif
    localparam logic [3:0] LAST_BEAT = 4'(LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0] mux_data_q;
    logic             out_valid_q;

    logic load_en;
    logic beat;
    logic cur_valid;    // valid of the currently granted source
    logic oth_valid;    // valid of the waiting source
    logic oth_idx;      // index of the waiting source

    // The output register can take a new word when it is empty or being drained.
    assign load_en = !out_valid_q | out_ready;

    assign sel     = (state_q == GRANT1);
    assign ready_0 = (state_q == GRANT0) & load_en;
    assign ready_1 = (state_q == GRANT1) & load_en;
    assign beat    = (valid_0 & ready_0) | (valid_1 & ready_1);

    assign cur_valid = sel ? valid_1 : valid_0;
    assign oth_valid = sel ? valid_0 : valid_1;
    assign oth_idx   = ~sel;

    assign mux_data  = mux_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (valid_0 || valid_1) begin
                    // On a tie the source that was not served last wins.
                    if (valid_0 && valid_1) begin
                        last_d = ~last_q;
                    end else begin
                        last_d = valid_1;
                    end
                    state_d    = last_d ? GRANT1 : GRANT0;
                    beat_cnt_d = 4'd0;
                end
            end
            GRANT0, GRANT1: begin
                if (!cur_valid) begin
                    // Granted source dropped: hand over or go idle.
                    if (oth_valid) begin
                        state_d    = oth_idx ? GRANT1 : GRANT0;
                        last_d     = oth_idx;
                        beat_cnt_d = 4'd0;
                    end else begin
                        state_d    = IDLE;
                    end
                end else if (beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        // Switch on the edge of the final beat, so no bubble.
                        beat_cnt_d = 4'd0;
                        if (oth_valid) begin
                            state_d = oth_idx ? GRANT1 : GRANT0;
                            last_d  = oth_idx;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            beat_cnt_q  <= 4'd0;
            mux_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            if (beat) begin
                // Capture the mux output as selected by the current grant.
                mux_data_q  <= sel ? din_1 : din_0;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
